i2c_slave: RTL

- Target-side (responder) counterpart to the team's I2C master controller. Uses the same simplified single-clock framing.
- Detects a start, shifts in a 7-bit address plus R/W bit LSB-first, and acknowledges on an address match.
- On a master write, captures one data byte. On a master read, serializes one byte onto sda.
- Sits on the shared scl/sda pair next to the master. Presents a simple byte interface to local logic.

---
 rtl/i2c_slave.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Brief    : Simplified single-clock I2C responder: address match, one-byte
//            write capture or one-byte read serialisation on sda.
// Revision : 1.0
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
    input  logic       scl,
    input  logic       rst,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_taken,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ARMED  = 4'd1,
        S_ADDR   = 4'd2,
        S_ACK1   = 4'd3,
        S_RX     = 4'd4,
        S_ACK2   = 4'd5,
        S_TX_PAD = 4'd6,
        S_TX     = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t     r_state, w_state;
    logic [2:0] r_cnt, w_cnt, w_cnt_inc;
    logic [7:0] r_sreg, w_sreg, w_shift;
    logic [7:0] r_tx, w_tx;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_rd_taken, w_rd_taken;
    logic       r_addr_match, w_addr_match;
    logic       r_oe, w_oe;
    logic       r_do, w_do;
    logic       w_sda_in;

    // Anything other than a solid 0 on the bus is read as a released line.
    assign w_sda_in  = (sda === 1'b0) ? 1'b0 : 1'b1;
    assign w_cnt_inc = r_cnt + 3'd1;

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_sreg       = r_sreg;
        w_tx         = r_tx;
        w_rx_data    = r_rx_data;
        w_rx_valid   = 1'b0;
        w_rd_taken   = 1'b0;
        w_addr_match = r_addr_match;
        w_oe         = 1'b0;
        w_do         = 1'b0;
        w_shift          = r_sreg;
        w_shift[r_cnt]   = w_sda_in;

        case (r_state)
            S_IDLE: begin
                w_addr_match = 1'b0;
                if (w_sda_in) begin
                    w_state = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!w_sda_in) begin
                    w_state = S_ADDR;
                    w_cnt   = 3'd0;
                end
            end
            S_ADDR: begin
                w_sreg = w_shift;
                w_cnt  = w_cnt_inc;
                if (r_cnt == 3'd7) begin
                    if (w_shift[7:1] == SLAVE_ADDR) begin
                        w_state      = S_ACK1;
                        w_oe         = 1'b1;
                        w_addr_match = 1'b1;
                        w_rd_taken   = ~w_shift[0];
                    end else begin
                        w_state = S_IDLE;
                    end
                end
            end
            S_ACK1: begin
                w_cnt = 3'd0;
                if (r_sreg[0]) begin
                    w_state = S_RX;
                end else begin
                    w_state = S_TX_PAD;
                    w_tx    = tx_data;
                    w_oe    = 1'b1;
                end
            end
            S_RX: begin
                // The address bits left in the shift register are fully overwritten here.
                w_sreg = w_shift;
                w_cnt  = w_cnt_inc;
                if (r_cnt == 3'd7) begin
                    w_state    = S_ACK2;
                    w_oe       = 1'b1;
                    w_rx_data  = w_shift;
                    w_rx_valid = 1'b1;
                end
            end
            S_ACK2: begin
                w_state = S_DONE;
            end
            S_TX_PAD: begin
                w_state = S_TX;
                w_cnt   = 3'd0;
                w_oe    = 1'b1;
                w_do    = r_tx[0];
            end
            S_TX: begin
                w_cnt = w_cnt_inc;
                if (r_cnt == 3'd7) begin
                    w_state = S_DONE;
                end else begin
                    w_oe = 1'b1;
                    w_do = r_tx[w_cnt_inc];
                end
            end
            S_DONE: begin
                w_state      = S_IDLE;
                w_addr_match = 1'b0;
            end
            default: begin
                w_state      = S_IDLE;
                w_addr_match = 1'b0;
            end
        endcase
    end

    always_ff @(posedge scl or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_sreg       <= 8'd0;
            r_tx         <= 8'd0;
            r_rx_data    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rd_taken   <= 1'b0;
            r_addr_match <= 1'b0;
            r_oe         <= 1'b0;
            r_do         <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_sreg       <= w_sreg;
            r_tx         <= w_tx;
            r_rx_data    <= w_rx_data;
            r_rx_valid   <= w_rx_valid;
            r_rd_taken   <= w_rd_taken;
            r_addr_match <= w_addr_match;
            r_oe         <= w_oe;
            r_do         <= w_do;
        end
    end

    assign sda        = r_oe ? r_do : 1'bz;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rd_taken   = r_rd_taken;
    assign addr_match = r_addr_match;
    assign busy       = (r_state != S_IDLE) && (r_state != S_ARMED);

endmodule
`default_nettype wire
